// File: rtl/ppu_vec_pipe.sv
// ppu_vec_pipe
//   Three-stage post-processing datapath for the accelerator output path.
//   Each VL-lane accumulator vector goes through four steps:
//     - multiply by a per-row scale
//     - add a per-row bias
//     - apply the selected activation
//     - round half away from zero and saturate symmetrically to OUT_W bits
//   A job of i_num_vec vectors is started by i_start. Input and output both
//   use valid/ready, with full backpressure.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_tbl_we/addr       write strobe and row index for the scale/bias tables
//   i_tbl_scale/bias    full row of per-lane scale and bias values
//   i_start             job start pulse (honoured only when idle)
//   i_num_vec           number of vectors in the job (0 = empty job)
//   i_base_addr         address tagged on the first output vector
//   i_act               0 none, 1 relu, 2 leaky (>>>3), 3 none
//   i_in_valid/o_in_ready, i_acc_data        input vector handshake
//   o_out_valid/i_out_ready, o_out_data/addr output vector handshake
//   o_busy              job in progress
//   o_done              one-cycle pulse when the job's last vector leaves
module ppu_vec_pipe #(
  parameter int VL      = 16,
  parameter int ACC_W   = 24,
  parameter int SCALE_W = 16,
  parameter int BIAS_W  = 32,
  parameter int FRAC    = 10,
  parameter int OUT_W   = 18,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_tbl_we,
  input  logic [$clog2(DEPTH)-1:0] i_tbl_addr,
  input  logic [SCALE_W*VL-1:0]    i_tbl_scale,
  input  logic [BIAS_W*VL-1:0]     i_tbl_bias,
  input  logic                     i_start,
  input  logic [ADDR_W-1:0]        i_num_vec,
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic [1:0]               i_act,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [ACC_W*VL-1:0]      i_acc_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [OUT_W*VL-1:0]      o_out_data,
  output logic [ADDR_W-1:0]        o_out_addr,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PROD_W = ACC_W + SCALE_W;
  // One guard bit over the wider addend, so the bias add can never overflow.
  localparam int SUM_W  = ((PROD_W > BIAS_W) ? PROD_W : BIAS_W) + 1;
  // One more bit again, so that |sum| fits as an unsigned magnitude.
  localparam int MAG_W  = SUM_W + 1;
  localparam logic [MAG_W-1:0] HALF    = MAG_W'(64'd1 << (FRAC - 1));
  localparam logic [MAG_W-1:0] SAT_MAX = MAG_W'((64'd1 << (OUT_W - 1)) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] num_vec;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        act_sel;
  logic [ADDR_W-1:0] in_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic              zero_done;

  logic en;
  logic in_fire;
  logic out_fire;
  logic job_start;
  logic last_out;

  logic [SCALE_W*VL-1:0] scale_tbl [DEPTH];
  logic [BIAS_W*VL-1:0]  bias_tbl  [DEPTH];

  logic [IDX_W-1:0]         in_idx;
  logic [SCALE_W*VL-1:0]    scale_row;
  logic [BIAS_W*VL-1:0]     bias_row;
  logic signed [PROD_W-1:0] prod_next [VL];
  logic signed [SUM_W-1:0]  act_next  [VL];
  logic [OUT_W*VL-1:0]      out_next;

  logic                     s1_valid;
  logic signed [PROD_W-1:0] s1_prod [VL];
  logic [IDX_W-1:0]         s1_idx;
  logic [ADDR_W-1:0]        s1_addr;

  logic                     s2_valid;
  logic signed [SUM_W-1:0]  s2_val [VL];
  logic [ADDR_W-1:0]        s2_addr;

  // The whole pipe moves as one unit. It stalls only when the output
  // register holds a vector that downstream has not yet taken.
  assign en        = !o_out_valid || i_out_ready;
  assign o_in_ready = (state == RUN) && (in_cnt < num_vec) && en;
  assign in_fire   = o_in_ready && i_in_valid;
  assign out_fire  = o_out_valid && i_out_ready;
  assign job_start = (state == IDLE) && i_start && (i_num_vec != '0);
  assign last_out  = (out_cnt == num_vec - ADDR_W'(1));

  // Next-state and status outputs. o_done has two sources:
  //   - a completed job pulses it combinationally, in the cycle of the final
  //     output handshake;
  //   - an empty job pulses it from a register, one cycle after the start.
  always_comb begin
    state_next = state;
    o_busy     = (state != IDLE);
    o_done     = zero_done;
    case (state)
      IDLE: begin
        if (job_start) state_next = RUN;
      end
      RUN: begin
        if (in_cnt == num_vec) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_fire && last_out) begin
          state_next = IDLE;
          o_done     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Job control registers. The job parameters are captured at the start so
  // that the inputs are free to change while the job runs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      num_vec   <= '0;
      base_addr <= '0;
      act_sel   <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_next;
      zero_done <= (state == IDLE) && i_start && (i_num_vec == '0);
      if (job_start) begin
        num_vec   <= i_num_vec;
        base_addr <= i_base_addr;
        act_sel   <= i_act;
        in_cnt    <= '0;
        out_cnt   <= '0;
      end else begin
        if (in_fire)  in_cnt  <= in_cnt + ADDR_W'(1);
        if (out_fire) out_cnt <= out_cnt + ADDR_W'(1);
      end
    end
  end

  // Scale/bias tables. These are deliberately not reset. Writes are locked
  // out during a job, so that every vector of a job sees the same
  // coefficients. In the start cycle the unit is still idle, so a write
  // there still lands.
  always_ff @(posedge i_clk) begin
    if (i_tbl_we && !o_busy) begin
      scale_tbl[i_tbl_addr] <= i_tbl_scale;
      bias_tbl[i_tbl_addr]  <= i_tbl_bias;
    end
  end

  // S1 (combinational half): fetch the scale row and form the signed
  // products. The row index is the input count wrapped to the table depth.
  // Both operands are sign-extended to the full product width first, so the
  // multiply is exact.
  always_comb begin
    in_idx    = in_cnt[IDX_W-1:0];
    scale_row = scale_tbl[in_idx];
    for (int i = 0; i < VL; i++) prod_next[i] = '0;
    for (int i = 0; i < VL; i++) begin
      prod_next[i] =
        $signed({{SCALE_W{i_acc_data[i*ACC_W+ACC_W-1]}}, i_acc_data[i*ACC_W +: ACC_W]}) *
        $signed({{ACC_W{scale_row[i*SCALE_W+SCALE_W-1]}}, scale_row[i*SCALE_W +: SCALE_W]});
    end
  end

  // S1 register. The row index travels with the data so that S2 can fetch
  // the matching bias row.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_addr  <= '0;
      for (int i = 0; i < VL; i++) s1_prod[i] <= '0;
    end else if (en) begin
      s1_valid <= in_fire;
      s1_idx   <= in_idx;
      s1_addr  <= base_addr + in_cnt;
      for (int i = 0; i < VL; i++) s1_prod[i] <= prod_next[i];
    end
  end

  // S2 (combinational half): add the bias, then apply the activation.
  // Leaky uses an arithmetic shift, which rounds toward minus infinity.
  always_comb begin
    bias_row = bias_tbl[s1_idx];
    for (int i = 0; i < VL; i++) act_next[i] = '0;
    for (int i = 0; i < VL; i++) begin
      act_next[i] =
        $signed({{(SUM_W-PROD_W){s1_prod[i][PROD_W-1]}}, s1_prod[i]}) +
        $signed({{(SUM_W-BIAS_W){bias_row[i*BIAS_W+BIAS_W-1]}}, bias_row[i*BIAS_W +: BIAS_W]});
      case (act_sel)
        2'd1:    if (act_next[i][SUM_W-1]) act_next[i] = '0;
        2'd2:    if (act_next[i][SUM_W-1]) act_next[i] = act_next[i] >>> 3;
        default: act_next[i] = act_next[i];
      endcase
    end
  end

  // S2 register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      for (int i = 0; i < VL; i++) s2_val[i] <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      for (int i = 0; i < VL; i++) s2_val[i] <= act_next[i];
    end
  end

  // S3 (combinational half): the lane is processed as sign plus magnitude.
  // Adding half an LSB to the magnitude before truncating gives
  // round-half-away-from-zero. The result is clamped before the sign is
  // restored, so both signs saturate at the same magnitude and the most
  // negative code is never produced.
  always_comb begin
    logic             neg;
    logic [MAG_W-1:0] v_ext;
    logic [MAG_W-1:0] mag;
    logic [MAG_W-1:0] rnd;
    logic [OUT_W-1:0] clip;
    neg      = 1'b0;
    v_ext    = '0;
    mag      = '0;
    rnd      = '0;
    clip     = '0;
    out_next = '0;
    for (int i = 0; i < VL; i++) begin
      neg   = s2_val[i][SUM_W-1];
      v_ext = {s2_val[i][SUM_W-1], s2_val[i]};
      mag   = neg ? (MAG_W'(0) - v_ext) : v_ext;
      rnd   = (mag + HALF) >> FRAC;
      if (rnd > SAT_MAX) rnd = SAT_MAX;
      clip  = rnd[OUT_W-1:0];
      out_next[i*OUT_W +: OUT_W] = neg ? (OUT_W'(0) - clip) : clip;
    end
  end

  // Output register. While downstream stalls (en low) it holds its data and
  // address unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_addr  <= '0;
    end else if (en) begin
      o_out_valid <= s2_valid;
      o_out_data  <= out_next;
      o_out_addr  <= s2_addr;
    end
  end

endmodule

// File: tb/tb_ppu_vec_pipe.sv
// tb_ppu_vec_pipe
//   Directed bench for ppu_vec_pipe.
//   - A table of single-vector jobs covers scale, rounding, saturation and
//     the activation modes.
//   - Hand-written sequences cover the multi-vector job under random
//     backpressure, reset in mid-job, table writes while busy, and the empty
//     job.
module tb_ppu_vec_pipe;

  localparam int VL      = 16;
  localparam int ACC_W   = 24;
  localparam int SCALE_W = 16;
  localparam int BIAS_W  = 32;
  localparam int FRAC    = 10;
  localparam int OUT_W   = 18;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 10;
  localparam int IDX_W   = $clog2(DEPTH);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tbl_we;
  logic [IDX_W-1:0]      tbl_addr;
  logic [SCALE_W*VL-1:0] tbl_scale;
  logic [BIAS_W*VL-1:0]  tbl_bias;
  logic                  start;
  logic [ADDR_W-1:0]     num_vec;
  logic [ADDR_W-1:0]     base_addr;
  logic [1:0]            act;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_W*VL-1:0]   acc_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W*VL-1:0]   out_data;
  logic [ADDR_W-1:0]     out_addr;
  logic                  busy;
  logic                  done;

  int comp_count = 0;
  int fail_count = 0;

  typedef struct {
    int scale;
    int bias;
    int act;
    int acc;
    int expv;
  } vec_t;

  vec_t vecs [12];

  ppu_vec_pipe #(
    .VL(VL), .ACC_W(ACC_W), .SCALE_W(SCALE_W), .BIAS_W(BIAS_W),
    .FRAC(FRAC), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tbl_we    (tbl_we),
    .i_tbl_addr  (tbl_addr),
    .i_tbl_scale (tbl_scale),
    .i_tbl_bias  (tbl_bias),
    .i_start     (start),
    .i_num_vec   (num_vec),
    .i_base_addr (base_addr),
    .i_act       (act),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_acc_data  (acc_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_addr  (out_addr),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // Safety net, in case some wait below misbehaves.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    comp_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Every lane must carry the same expected value.
  task automatic checkVector(input string name, input int expv);
    int bad;
    logic [OUT_W-1:0] exp_bits;
    logic signed [OUT_W-1:0] lane0;
    bad = 0;
    exp_bits = expv[OUT_W-1:0];
    for (int i = 0; i < VL; i++)
      if (out_data[i*OUT_W +: OUT_W] !== exp_bits) bad++;
    lane0 = out_data[OUT_W-1:0];
    comp_count++;
    if (bad != 0) begin
      fail_count++;
      $display("[TB] FAIL %s: %0d lanes wrong, lane0 got %0d, expected %0d",
               name, bad, lane0, expv);
    end
  endtask

  task automatic setRow(input int idx, input int scale, input int bias);
    tbl_addr = idx[IDX_W-1:0];
    for (int i = 0; i < VL; i++) begin
      tbl_scale[i*SCALE_W +: SCALE_W] = scale[SCALE_W-1:0];
      tbl_bias[i*BIAS_W +: BIAS_W]    = bias[BIAS_W-1:0];
    end
  endtask

  task automatic loadRow(input int idx, input int scale, input int bias);
    tbl_we = 1'b1;
    setRow(idx, scale, bias);
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic setAcc(input int a);
    for (int i = 0; i < VL; i++) acc_data[i*ACC_W +: ACC_W] = a[ACC_W-1:0];
  endtask

  task automatic startJob(input int n, input int base, input int a);
    start     = 1'b1;
    num_vec   = n[ADDR_W-1:0];
    base_addr = base[ADDR_W-1:0];
    act       = a[1:0];
    tick();
    start = 1'b0;
  endtask

  // Offer one vector and return just after the edge that accepts it.
  task automatic acceptOne(input int a);
    int w;
    in_valid = 1'b1;
    setAcc(a);
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // One single-vector job from the table: row 0 is loaded, base address 5.
  task automatic applyStimulus(input vec_t v, input int n);
    int lat;
    loadRow(0, v.scale, v.bias);
    startJob(1, 5, v.act);
    acceptOne(v.acc);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput($sformatf("vec%0d_latency", n), lat, 3);
    checkVector($sformatf("vec%0d_data", n), v.expv);
    checkOutput($sformatf("vec%0d_addr", n), out_addr, 5);
    checkOutput($sformatf("vec%0d_done", n), done, 1);
    tick();
    checkOutput($sformatf("vec%0d_busy_after", n), busy, 0);
  endtask

  initial begin
    int sent, recv, dones, cyc, w;
    logic hold_pending;
    logic [OUT_W*VL-1:0] held_data;
    logic [ADDR_W-1:0]   held_addr;

    //          scale   bias  act  acc        expected
    vecs[0]  = '{1024,  0,    0,   300,       300};
    vecs[1]  = '{1536,  0,    0,   3,         5};
    vecs[2]  = '{1536,  0,    0,   -3,        -5};
    vecs[3]  = '{1536,  0,    0,   1,         2};
    vecs[4]  = '{32767, 0,    0,   8388607,   131071};
    vecs[5]  = '{32767, 0,    0,   -8388608,  -131071};
    vecs[6]  = '{1024,  0,    1,   -100,      0};
    vecs[7]  = '{1024,  0,    2,   -100,      -13};
    vecs[8]  = '{1024,  2048, 0,   10,        12};
    vecs[9]  = '{1024,  0,    3,   -100,      -100};
    vecs[10] = '{1024,  0,    1,   50,        50};
    vecs[11] = '{1024,  0,    2,   40,        40};

    rst = 1'b1;
    tbl_we = 1'b0; tbl_addr = '0; tbl_scale = '0; tbl_bias = '0;
    start = 1'b0; num_vec = '0; base_addr = '0; act = '0;
    in_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data[63:0], 0);
    checkOutput("reset_out_addr", out_addr, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 12; n++) applyStimulus(vecs[n], n);

    // Empty job: a done pulse one cycle later, and no busy.
    startJob(0, 0, 0);
    checkOutput("empty_done", done, 1);
    checkOutput("empty_busy", busy, 0);
    tick();
    checkOutput("empty_done_clear", done, 0);

    // A write in the start cycle lands; a write while busy is dropped.
    loadRow(0, 1024, 0);
    tbl_we = 1'b1;
    setRow(0, 2048, 0);
    startJob(1, 7, 0);
    setRow(0, 4096, 0);
    tick();
    tbl_we = 1'b0;
    acceptOne(100);
    w = 0;
    while (!out_valid && w < 10) begin
      tick();
      w++;
    end
    checkOutput("tblw_out_valid", out_valid, 1);
    checkVector("tblw_data", 200);
    checkOutput("tblw_addr", out_addr, 7);
    tick();

    // 20 vectors through 16 table rows, with random backpressure.
    for (int k = 0; k < DEPTH; k++) loadRow(k, 0, k * 1024);
    startJob(20, 1010, 0);
    sent = 0; recv = 0; dones = 0; cyc = 0;
    hold_pending = 1'b0; held_data = '0; held_addr = '0;
    while (recv < 20 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 20);
      setAcc(int'($urandom_range(0, 1000)));
      #1;
      if (hold_pending) begin
        checkOutput($sformatf("stall_valid_c%0d", cyc), out_valid, 1);
        comp_count++;
        if (out_data !== held_data || out_addr !== held_addr) begin
          fail_count++;
          $display("[TB] FAIL stall_hold_c%0d: got addr %0d lane0 %0d, expected addr %0d lane0 %0d",
                   cyc, out_addr, out_data[OUT_W-1:0], held_addr, held_data[OUT_W-1:0]);
        end
      end
      if (done) dones++;
      if (out_valid && out_ready) begin
        checkVector($sformatf("job_data_%0d", recv), recv % DEPTH);
        checkOutput($sformatf("job_addr_%0d", recv), out_addr, (1010 + recv) % 1024);
        recv++;
      end
      hold_pending = out_valid && !out_ready;
      held_data    = out_data;
      held_addr    = out_addr;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("job_sent", sent, 20);
    checkOutput("job_recv", recv, 20);
    checkOutput("job_done_count", dones, 1);
    checkOutput("job_busy_after", busy, 0);
    checkOutput("job_done_after", done, 0);
    tick();

    // Reset in mid-job: everything clears at once, and no done follows.
    loadRow(0, 1024, 0);
    startJob(4, 0, 0);
    in_valid = 1'b1;
    setAcc(5);
    w = 0;
    while (!out_valid && w < 10) begin
      tick();
      w++;
    end
    checkOutput("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_data", out_data[63:0], 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || out_valid) dones++;
    end
    checkOutput("rst_no_activity", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_count, fail_count);
    $finish;
  end

endmodule
